// File: rtl/sa_tile_if.sv
// Handshake and control bundle between a tile requester and the 2x2 systolic tile scheduler.
interface sa_tile_if #(
    parameter int KW = 8
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          clr_pe;
    logic [1:0]    feed_row;
    logic [1:0]    feed_col;
    logic [3:0]    pe_en;
    logic [KW-1:0] k_idx;

    modport master (
        output start, k_len, abort,
        input  busy, done, clr_pe, feed_row, feed_col, pe_en, k_idx
    );

    modport slave (
        input  start, k_len, abort,
        output busy, done, clr_pe, feed_row, feed_col, pe_en, k_idx
    );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Sequences one 2x2 systolic tile multiply: clear, skewed operand feed, drain, done pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, all outputs low
// ST_CLEAR | one cycle, clear the four PE accumulators
// ST_FEED  | K+2 cycles of skewed operand injection, counter c = 0..K+1
// ST_DRAIN | DRAIN cycles letting the last products settle
// ST_DONE  | one-cycle done pulse
module sa_tile_scheduler #(
    parameter int KW    = 8,
    parameter int DRAIN = 3
) (
    input  logic   clk,
    input  logic   rst,
    sa_tile_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [KW:0] C_ONE      = (KW+1)'(1);
    localparam logic [KW:0] C_TWO      = (KW+1)'(2);
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN - 1);

    state_t        state_q, state_d;
    logic [KW:0]   c_q, c_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    drain_q, drain_d;

    // K is extended by one bit so K+1 never wraps for K = 2^KW-1
    logic [KW:0] k_ext;
    logic [KW:0] k_plus1;
    assign k_ext   = {1'b0, k_q};
    assign k_plus1 = k_ext + C_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    k_d     = bus.k_len;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                c_d = '0;
                if (bus.abort)
                    state_d = ST_IDLE;
                else if (k_q == '0)
                    state_d = ST_DONE;
                else
                    state_d = ST_FEED;
            end
            ST_FEED: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (c_q == k_plus1) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    c_d = c_q + C_ONE;
                end
            end
            ST_DRAIN: begin
                if (bus.abort)
                    state_d = ST_IDLE;
                else if (drain_q == '0)
                    state_d = ST_DONE;
                else
                    drain_d = drain_q - 4'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic in_feed;
    logic lead;
    logic mid;
    logic tail;

    // Row/col 1 and the off-diagonal PEs lag by one cycle, PE22 by two
    assign in_feed = (state_q == ST_FEED);
    assign lead    = in_feed && (c_q < k_ext);
    assign mid     = in_feed && (c_q >= C_ONE) && (c_q <= k_ext);
    assign tail    = in_feed && (c_q >= C_TWO) && (c_q <= k_plus1);

    assign bus.busy     = (state_q == ST_CLEAR) || (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.clr_pe   = (state_q == ST_CLEAR);
    assign bus.feed_row = {mid, lead};
    assign bus.feed_col = {mid, lead};
    assign bus.pe_en    = {tail, mid, mid, lead};
    assign bus.k_idx    = lead ? c_q[KW-1:0] : '0;
endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: per-cycle comparison of the packed output vector.
module tb_sa_tile_scheduler;
    localparam int KW = 8;
    localparam int DR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sa_tile_if #(.KW(KW)) bus ();

    sa_tile_scheduler #(.KW(KW), .DRAIN(DR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {busy, done, clr_pe, feed_row, feed_col, pe_en, k_idx}
    function automatic logic [18:0] pk(input logic b, input logic d, input logic cl,
                                       input logic [1:0] fr, input logic [1:0] fc,
                                       input logic [3:0] pe, input logic [7:0] ki);
        return {b, d, cl, fr, fc, pe, ki};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.busy, bus.done, bus.clr_pe, bus.feed_row, bus.feed_col, bus.pe_en, bus.k_idx};
    endfunction

    // Expected outputs t cycles after the edge that accepted start (t=1 is CLEAR)
    function automatic logic [18:0] expected(input int k, input int t);
        int   c;
        logic a, m, l;
        if (t == 1) return pk(1, 0, 1, 0, 0, 0, 0);
        if (k == 0) return (t == 2) ? pk(0, 1, 0, 0, 0, 0, 0) : '0;
        if (t <= k + 3) begin
            c = t - 2;
            a = (c < k);
            m = (c >= 1) && (c <= k);
            l = (c >= 2) && (c <= k + 1);
            return pk(1, 0, 0, {m, a}, {m, a}, {l, m, m, a}, a ? 8'(c) : 8'd0);
        end
        if (t <= k + 3 + DR) return pk(1, 0, 0, 0, 0, 0, 0);
        if (t == k + 4 + DR) return pk(0, 1, 0, 0, 0, 0, 0);
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 plain, 1 start(k_len=5) pulse at at_t, 2 abort at at_t, 3 rst at at_t,
    // 4 abort held together with start in IDLE
    task automatic run(input int k, input int n, input int kind, input int at_t, input string tag);
        logic [18:0] e;
        bus.start = 1'b1;
        bus.k_len = 8'(k);
        if (kind == 4) bus.abort = 1'b1;
        for (int t = 1; t <= n; t++) begin
            step();
            if (t == 1) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end
            e = expected(k, t);
            if ((kind == 2 || kind == 3) && t > at_t) e = '0;
            check($sformatf("%s t=%0d", tag, t), 32'(observed()), 32'(e));
            if (t == at_t) begin
                case (kind)
                    1: begin bus.start = 1'b1; bus.k_len = 8'd5; end
                    2: bus.abort = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
            end else if (t == at_t + 1) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                rst       = 1'b0;
            end
        end
    endtask

    logic [18:0] k3_tab [1:12];

    initial begin
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;

        k3_tab[1]  = pk(1, 0, 1, 2'd0, 2'd0, 4'd0,  8'd0);
        k3_tab[2]  = pk(1, 0, 0, 2'd1, 2'd1, 4'd1,  8'd0);
        k3_tab[3]  = pk(1, 0, 0, 2'd3, 2'd3, 4'd7,  8'd1);
        k3_tab[4]  = pk(1, 0, 0, 2'd3, 2'd3, 4'd15, 8'd2);
        k3_tab[5]  = pk(1, 0, 0, 2'd2, 2'd2, 4'd14, 8'd0);
        k3_tab[6]  = pk(1, 0, 0, 2'd0, 2'd0, 4'd8,  8'd0);
        k3_tab[7]  = pk(1, 0, 0, 2'd0, 2'd0, 4'd0,  8'd0);
        k3_tab[8]  = pk(1, 0, 0, 2'd0, 2'd0, 4'd0,  8'd0);
        k3_tab[9]  = pk(1, 0, 0, 2'd0, 2'd0, 4'd0,  8'd0);
        k3_tab[10] = pk(0, 1, 0, 2'd0, 2'd0, 4'd0,  8'd0);
        k3_tab[11] = '0;
        k3_tab[12] = '0;

        // reset overrides a start request
        bus.start = 1'b1;
        bus.k_len = 8'd7;
        step(); step(); step();
        check("reset_outputs", 32'(observed()), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        step();
        check("idle_after_reset", 32'(observed()), 32'd0);

        // nominal K=3 run against the hand-built table
        bus.start = 1'b1;
        bus.k_len = 8'd3;
        for (int t = 1; t <= 12; t++) begin
            step();
            bus.start = 1'b0;
            check($sformatf("k3_table t=%0d", t), 32'(observed()), 32'(k3_tab[t]));
        end

        run(0,   5,   0, 0, "k0");
        run(3,   12,  1, 4, "k3_start_in_feed");
        run(3,   8,   2, 3, "abort_feed");
        run(2,   12,  0, 0, "after_abort");
        run(3,   12,  3, 8, "rst_drain");
        run(2,   12,  0, 0, "after_rst");
        run(1,   10,  4, 0, "start_with_abort");
        run(2,   12,  1, 9, "start_in_done");
        run(255, 265, 0, 0, "k255");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
